uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between `NUM_REQ` byte producers, e.g. a Wishbone register port, a debug console and status reporters. It accepts one byte at a time from the winning requester and issues it to the transmitter through the transmitter's write/busy handshake. It then tracks the frame to completion before granting again. It sits between the requesters and the UART TX block; the transmitter's baud timing and framing are unchanged.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to add i_lock, which keeps a requester's multi-byte message contiguous.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           i_lock,
`endif
  output logic [NUM_REQ-1:0]           o_ack,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                         o_tx_write,
  output logic [DATA_BITS-1:0]         o_tx_data,
  input  logic                         i_tx_busy,
  output logic                         o_active,
  output logic                         o_err
);

  // state        | meaning
  // S_IDLE       | arbitrate; latch winner's byte and ack it
  // S_ISSUE      | wait for transmitter idle, pulse o_tx_write
  // S_WAIT_START | wait up to START_TIMEOUT cycles for busy to rise
  // S_WAIT_DONE  | wait for the frame to finish (busy low)

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(START_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0]   req_eff;
  logic [ID_W:0]        cand_sum;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [DATA_BITS-1:0] win_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic granted_q, granted_d;
`endif

  // Round-robin search upward from last+1, wrapping modulo NUM_REQ.
  always_comb begin
    req_eff = i_req;
`ifdef UART_TX_ARB_LOCK_EN
    if (granted_q && i_lock[last_q]) begin
      req_eff = '0;
      req_eff[last_q] = i_req[last_q];
    end
`endif
    cand_sum  = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_sum = {1'b0, last_q} + (ID_W+1)'(i);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      if (!win_found && req_eff[cand_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) win_data = i_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    data_d     = data_q;
    ack_d      = '0;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;
    o_tx_write = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    granted_d  = granted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          last_d  = win_id;
          grant_d = win_id;
          data_d  = win_data;
          for (int k = 0; k < NUM_REQ; k++) ack_d[k] = (win_id == ID_W'(k));
`ifdef UART_TX_ARB_LOCK_EN
          granted_d = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        if (!i_tx_busy) begin
          o_tx_write = 1'b1;
          to_cnt_d   = TO_LOAD;
          state_d    = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_ONE) begin
          // Transmitter never started: byte is dropped, not retried.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      to_cnt_q  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      granted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      active_q  <= active_d;
      to_cnt_q  <= to_cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
      granted_q <= granted_d;
`endif
    end
  end

  assign o_ack      = ack_q;
  assign o_grant_id = grant_q;
  assign o_tx_data  = data_q;
  assign o_active   = active_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences, and a random run
// checked against a round-robin reference model; lock sequence runs when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic [1:0]  o_grant_id;
  logic        o_tx_write;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        o_active;
  logic        o_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  i_lock;
  logic [3:0]  lck_mask;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .START_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
`ifdef UART_TX_ARB_LOCK_EN
    .i_lock(i_lock),
`endif
    .o_ack(o_ack), .o_grant_id(o_grant_id), .o_tx_write(o_tx_write), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_active(o_active), .o_err(o_err)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[11];
  int   n_chk = 0, n_err = 0, cyc = 0, wr_cnt = 0;
  int   tx_cnt = 0, frame_len = 3;
  bit   tx_dead = 0, force_busy = 0, busy_fell = 0, wr_s = 0;
  logic [7:0]  wr_data = '0;
  logic [31:0] data_s = '0;
  int   rem[4];
  int   got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample comb outputs before the edge, then advance the transmitter model.
  task automatic step();
    #1;
    data_s = i_data;
    wr_s   = o_tx_write;
    if (wr_s) begin
      wr_cnt++;
      wr_data = o_tx_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tx_cnt > 0) tx_cnt--;
    if (wr_s && !tx_dead) tx_cnt = frame_len;
    busy_fell = i_tx_busy && !force_busy && (tx_cnt == 0);
    i_tx_busy = force_busy || (tx_cnt > 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req = '0;
    force_busy = 0;
    tx_dead = 0;
    step();
    step();
    i_rst_n = 1'b1;
    tx_cnt = 0;
    i_tx_busy = 1'b0;
  endtask

  function automatic int ack_id(input logic [3:0] a);
    case (a)
      4'b0000: return -1;
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -2;
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int k);
    logic [31:0] s;
    s = d >> (8 * k);
    return s[7:0];
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (o_active && n < 40) begin
      step();
      n++;
    end
    chk({name, "_drained"}, {31'd0, o_active}, 32'd0);
  endtask

  task automatic run_vec(input int v);
    int wr0, fall_cyc, idle_cyc;
    string nm;
    nm = $sformatf("vec%0d", v);
    i_req  = vecs[v].req;
    i_data = vecs[v].data;
    wr0 = wr_cnt;
    step();
    chk({nm, "_ack"}, o_ack, 32'(1) << vecs[v].exp_id);
    chk({nm, "_grant"}, o_grant_id, vecs[v].exp_id);
    chk({nm, "_tx_data"}, o_tx_data, vecs[v].exp_byte);
    i_req = '0;
    fall_cyc = -100;
    idle_cyc = -1;
    for (int k = 0; k < 30 && idle_cyc < 0; k++) begin
      step();
      if (busy_fell) fall_cyc = cyc;
      if (!o_active) idle_cyc = cyc;
    end
    chk({nm, "_writes"}, wr_cnt - wr0, 1);
    chk({nm, "_write_byte"}, wr_data, vecs[v].exp_byte);
    chk({nm, "_active_fall"}, idle_cyc - fall_cyc, 1);
  endtask

  // Requesters with rem[k] bytes each; 'late' requesters join after the first grant.
  task automatic run_grants(input string name, input int n, input logic [3:0] late);
    bit started;
    int id, wr0;
    logic [31:0] d;
    started = 0;
    wr0 = wr_cnt;
    got_q.delete();
    for (int c = 0; c < 200 && got_q.size() < n; c++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        i_req[k] = (rem[k] > 0) && (!late[k] || started);
        d = d | (32'((k * 16 + rem[k]) & 8'hFF) << (8 * k));
      end
      i_data = d;
`ifdef UART_TX_ARB_LOCK_EN
      i_lock = lck_mask & i_req;
`endif
      step();
      id = ack_id(o_ack);
      chk({name, "_ack_onehot"}, {31'd0, id != -2}, 32'd1);
      if (id >= 0) begin
        chk({name, "_byte"}, o_tx_data, byte_of(data_s, id));
        got_q.push_back(id);
        rem[id]--;
        started = 1;
      end
    end
    i_req = '0;
`ifdef UART_TX_ARB_LOCK_EN
    i_lock = '0;
`endif
    drain(name);
    chk({name, "_acks_eq_writes"}, wr_cnt - wr0, got_q.size());
  endtask

  initial begin
    int wr0, a_cyc, exp_id, last_m, ready_at, n_acks;
    int gap[4];
    bit rq[4];
    logic [7:0] bytes[4];
    logic [31:0] d;

    vecs[0]  = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    vecs[1]  = '{4'b0001, 32'h1122_3344, 0, 8'h44};
    vecs[2]  = '{4'b1010, 32'h8899_AABB, 1, 8'hAA};
    vecs[3]  = '{4'b1010, 32'h0102_0304, 3, 8'h01};
    vecs[4]  = '{4'b1010, 32'hF0E0_D0C0, 1, 8'hD0};
    vecs[5]  = '{4'b1000, 32'h5A6B_7C8D, 3, 8'h5A};
    vecs[6]  = '{4'b0110, 32'h1357_9BDF, 1, 8'h9B};
    vecs[7]  = '{4'b1101, 32'h2468_ACE0, 2, 8'h68};
    vecs[8]  = '{4'b0011, 32'hDEAD_BEEF, 0, 8'hEF};
    vecs[9]  = '{4'b1001, 32'hCAFE_F00D, 3, 8'hCA};
    vecs[10] = '{4'b1111, 32'h7654_3210, 0, 8'h10};

    i_data = '0;
    i_tx_busy = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    i_lock = '0;
    lck_mask = '0;
`endif
    do_reset();
    chk("reset_ack", o_ack, 0);
    chk("reset_grant", o_grant_id, 0);
    chk("reset_tx_data", o_tx_data, 0);
    chk("reset_active", {31'd0, o_active}, 0);
    chk("reset_err", {31'd0, o_err}, 0);
    #1;
    chk("reset_tx_write", {31'd0, o_tx_write}, 0);

    for (int v = 0; v < 11; v++) run_vec(v);

    // ISSUE holds without a write while the transmitter is still busy.
    force_busy = 1;
    i_tx_busy = 1'b1;
    i_req = 4'b0100;
    i_data = 32'h00C3_0000;
    wr0 = wr_cnt;
    step();
    chk("hold_ack", o_ack, 4'b0100);
    i_req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_no_write", {31'd0, o_tx_write}, 0);
      step();
    end
    force_busy = 0;
    i_tx_busy = 1'b0;
    #1;
    chk("hold_release_write", {31'd0, o_tx_write}, 1);
    drain("hold");
    chk("hold_writes", wr_cnt - wr0, 1);

    // All four held continuously.
    do_reset();
    rem = '{100, 100, 100, 100};
    run_grants("all4", 5, 4'b0000);
    chk("all4_count", got_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < got_q.size()) chk($sformatf("all4_order%0d", k), got_q[k], k % 4);

    // Requester 2 streams, requester 0 joins once during its frame.
    rem = '{1, 0, 100, 0};
    run_grants("fair", 3, 4'b0001);
    chk("fair_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("fair_g0", got_q[0], 2);
      chk("fair_g1", got_q[1], 0);
      chk("fair_g2", got_q[2], 2);
    end

    // Start timeout: transmitter never raises busy.
    tx_dead = 1;
    i_req = 4'b0010;
    i_data = 32'h0000_7E00;
    wr0 = wr_cnt;
    step();
    a_cyc = cyc;
    chk("to_ack", o_ack, 4'b0010);
    i_req = '0;
    for (int k = 0; k < 4; k++) step();
    chk("to_err_before", {31'd0, o_err}, 0);
    chk("to_active_before", {31'd0, o_active}, 1);
    step();
    chk("to_cycles", cyc - a_cyc, 5);
    chk("to_err_after", {31'd0, o_err}, 1);
    chk("to_active_after", {31'd0, o_active}, 0);
    chk("to_one_write", wr_cnt - wr0, 1);
    tx_dead = 0;
    i_req = 4'b1000;
    i_data = 32'h3C00_0000;
    step();
    chk("to_next_ack", o_ack, 4'b1000);
    chk("to_next_byte", o_tx_data, 8'h3C);
    i_req = '0;
    drain("to_next");
    chk("to_err_sticky", {31'd0, o_err}, 1);

    // Reset during WAIT_DONE; the transmitter keeps sending its frame.
    frame_len = 8;
    i_req = 4'b0100;
    i_data = 32'h0099_0000;
    step();
    chk("mid_ack", o_ack, 4'b0100);
    i_req = '0;
    step();
    step();
    step();
    chk("mid_busy_active", {31'd0, o_active}, 1);
    i_rst_n = 1'b0;
    step();
    chk("mid_rst_active", {31'd0, o_active}, 0);
    chk("mid_rst_err", {31'd0, o_err}, 0);
    chk("mid_rst_grant", o_grant_id, 0);
    chk("mid_rst_ack", o_ack, 0);
    i_rst_n = 1'b1;
    i_req = 4'b0001;
    i_data = 32'h0000_0042;
    wr0 = wr_cnt;
    step();
    chk("mid_after_ack", o_ack, 4'b0001);
    i_req = '0;
    drain("mid_after");
    chk("mid_after_writes", wr_cnt - wr0, 1);
    chk("mid_after_byte", wr_data, 8'h42);
    frame_len = 3;

    // Random traffic against the round-robin reference model.
    do_reset();
    last_m = 3;
    ready_at = cyc;
    n_acks = 0;
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      rq[k] = 0;
      gap[k] = $urandom_range(0, 5);
      bytes[k] = 8'($urandom);
    end
    for (int c = 0; c < 900; c++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        if (!rq[k]) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            rq[k] = 1;
            bytes[k] = 8'($urandom);
          end
        end
        i_req[k] = rq[k];
        d = d | (32'(bytes[k]) << (8 * k));
      end
      i_data = d;
      frame_len = $urandom_range(1, 4);
      exp_id = (cyc >= ready_at) ? rr_pick(i_req, last_m) : -1;
      step();
      chk("rand_ack", o_ack, (exp_id < 0) ? 32'd0 : (32'(1) << exp_id));
      if (exp_id >= 0) begin
        n_acks++;
        ready_at = INF;
        last_m = exp_id;
        chk("rand_grant", o_grant_id, exp_id);
        chk("rand_byte", o_tx_data, bytes[exp_id]);
        if ($urandom_range(0, 1) == 1) bytes[exp_id] = 8'($urandom);
        else begin
          rq[exp_id] = 0;
          gap[exp_id] = $urandom_range(0, 6);
        end
      end
      if (busy_fell && ready_at == INF) ready_at = cyc + 1;
      chk("rand_active", {31'd0, o_active}, {31'd0, cyc < ready_at});
    end
    i_req = '0;
    drain("rand");
    chk("rand_writes", wr_cnt - wr0, n_acks);

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 1 locks for three bytes while requester 0 waits.
    do_reset();
    lck_mask = 4'b0010;
    rem = '{1, 3, 0, 0};
    run_grants("lock", 4, 4'b0001);
    chk("lock_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("lock_g0", got_q[0], 1);
      chk("lock_g1", got_q[1], 1);
      chk("lock_g2", got_q[2], 1);
      chk("lock_g3", got_q[3], 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
